// File: rtl/quad_encoder_emu_if.sv
// Signal bundle between the game-core side and the quadrature encoder emulator.
// Every channel occupies one bit of each vector and one byte of target/pos.
interface quad_encoder_emu_if #(
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 16
);
  logic [DIV_W-1:0]      clkdiv;
  logic [CHANNELS-1:0]   mode;
  logic [CHANNELS-1:0]   left;
  logic [CHANNELS-1:0]   right;
  logic [8*CHANNELS-1:0] target;
  logic [CHANNELS-1:0]   ext_a;
  logic [CHANNELS-1:0]   ext_b;
  logic [CHANNELS-1:0]   enc_a;
  logic [CHANNELS-1:0]   enc_b;
  logic [CHANNELS-1:0]   ext_sel;
  logic [8*CHANNELS-1:0] pos;

  modport master (
    output clkdiv, mode, left, right, target, ext_a, ext_b,
    input  enc_a, enc_b, ext_sel, pos
  );

  modport slave (
    input  clkdiv, mode, left, right, target, ext_a, ext_b,
    output enc_a, enc_b, ext_sel, pos
  );
endinterface

// File: rtl/quad_encoder_emu.sv
// Quadrature encoder emulator: per-channel accelerating step generator with
// Gray-coded A/B outputs and automatic hand-over to a physical encoder.
module quad_encoder_emu #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int ACCEL_STEPS = 16
) (
  input logic               clk_sys,
  input logic               reset,
  quad_encoder_emu_if.slave bus
);

  localparam int RUN_W = (ACCEL_STEPS < 2) ? 1 : $clog2(ACCEL_STEPS);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(ACCEL_STEPS - 1);
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

  function automatic logic [1:0] gray_phase(input logic [7:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] presc_r, presc_nxt_s, cur_presc_s, shifted_s, eff_div_s;
    logic [RUN_W-1:0] run_r, run_nxt_s, cur_run_s;
    logic [1:0]       stage_r, stage_nxt_s, cur_stage_s;
    logic [7:0]       pos_r, pos_nxt_s, tgt_s;
    logic [1:0]       dir_s, dir_prev_r;
    logic             mode_prev_r, restart_s, step_s;
    logic [1:0]       sync1_r, sync2_r, ext_prev_r;
    logic             sel_r, sel_nxt_s;
    logic             enc_a_r, enc_b_r;

    // Requested direction from either the digital buttons or the paddle target.
    always_comb begin
      tgt_s = bus.target[8*g +: 8];
      dir_s = DIR_NONE;
      if (bus.mode[g]) begin
        if (pos_r < tgt_s) begin
          dir_s = DIR_UP;
        end else if (pos_r > tgt_s) begin
          dir_s = DIR_DN;
        end else begin
          dir_s = DIR_NONE;
        end
      end else begin
        if (bus.right[g] && !bus.left[g]) begin
          dir_s = DIR_UP;
        end else if (bus.left[g] && !bus.right[g]) begin
          dir_s = DIR_DN;
        end else begin
          dir_s = DIR_NONE;
        end
      end
    end

    // A change of direction or mode restarts from a clean slate in the same
    // cycle, so the first step is always a full base period away.
    always_comb begin
      restart_s   = (dir_s != dir_prev_r) || (bus.mode[g] != mode_prev_r);
      cur_presc_s = restart_s ? '0 : presc_r;
      cur_run_s   = restart_s ? '0 : run_r;
      cur_stage_s = restart_s ? 2'd0 : stage_r;
      shifted_s   = bus.clkdiv >> cur_stage_s;
      eff_div_s   = (shifted_s == '0) ? DIV_W'(1) : shifted_s;
      step_s      = (bus.clkdiv != '0) && (dir_s != DIR_NONE) &&
                    (cur_presc_s == (eff_div_s - DIV_W'(1)));

      presc_nxt_s = '0;
      run_nxt_s   = cur_run_s;
      stage_nxt_s = cur_stage_s;
      pos_nxt_s   = pos_r;
      if ((bus.clkdiv == '0) || (dir_s == DIR_NONE) || step_s) begin
        presc_nxt_s = '0;
      end else begin
        presc_nxt_s = cur_presc_s + DIV_W'(1);
      end
      if (step_s) begin
        pos_nxt_s = (dir_s == DIR_UP) ? (pos_r + 8'd1) : (pos_r - 8'd1);
        if (cur_run_s == RUN_LAST) begin
          run_nxt_s   = '0;
          stage_nxt_s = (cur_stage_s == 2'd2) ? 2'd2 : (cur_stage_s + 2'd1);
        end else begin
          run_nxt_s   = cur_run_s + RUN_W'(1);
          stage_nxt_s = cur_stage_s;
        end
      end else begin
        pos_nxt_s = pos_r;
      end
    end

    // An internal step takes priority over an external edge for ownership.
    always_comb begin
      if (step_s) begin
        sel_nxt_s = 1'b0;
      end else if (sync2_r != ext_prev_r) begin
        sel_nxt_s = 1'b1;
      end else begin
        sel_nxt_s = sel_r;
      end
    end

    // Channel state, synchroniser and registered quadrature outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        presc_r     <= '0;
        run_r       <= '0;
        stage_r     <= 2'd0;
        pos_r       <= 8'd0;
        dir_prev_r  <= DIR_NONE;
        mode_prev_r <= 1'b0;
        sync1_r     <= 2'b00;
        sync2_r     <= 2'b00;
        ext_prev_r  <= 2'b00;
        sel_r       <= 1'b0;
        enc_a_r     <= 1'b0;
        enc_b_r     <= 1'b0;
      end else begin
        presc_r     <= presc_nxt_s;
        run_r       <= run_nxt_s;
        stage_r     <= stage_nxt_s;
        pos_r       <= pos_nxt_s;
        dir_prev_r  <= dir_s;
        mode_prev_r <= bus.mode[g];
        sync1_r     <= {bus.ext_a[g], bus.ext_b[g]};
        sync2_r     <= sync1_r;
        ext_prev_r  <= sync2_r;
        sel_r       <= sel_nxt_s;
        {enc_a_r, enc_b_r} <= sel_r ? sync2_r : gray_phase(pos_r);
      end
    end

    assign bus.pos[8*g +: 8] = pos_r;
    assign bus.ext_sel[g]    = sel_r;
    assign bus.enc_a[g]      = enc_a_r;
    assign bus.enc_b[g]      = enc_b_r;
  end

endmodule
